// File: rtl/spi_slave_responder_if.sv
// -----------------------------------------------------------------------------
// spi_slave_responder_if
//
// Bundles the SPI pins and the local reply/receive handshake of
// spi_slave_responder so that both travel as one port.
//
// Parameter
//   DATA_WIDTH   bits per SPI word; must match the responder's DATA_WIDTH
//
// Signals (direction as seen from the slave modport)
//   spi_sclk     in   SPI clock from the master, idles low
//   spi_ss_n     in   slave select, active low
//   spi_mosi     in   serial data from the master
//   spi_miso     out  serial data to the master
//   spi_miso_oe  out  MISO output enable, high while selected
//   tx_data      in   reply word offered to the holding register
//   tx_load      in   write strobe for tx_data, honoured only when tx_ready=1
//   tx_ready     out  holding register is empty
//   tx_underrun  out  one-cycle pulse: a word started with the default reply
//   rx_data      out  last complete received word
//   rx_valid     out  one-cycle pulse: rx_data was just updated
//   busy         out  responder is inside a frame
//
// The master modport is the mirror image, for a bench or an on-chip master.
// -----------------------------------------------------------------------------
interface spi_slave_responder_if #(
   parameter int DATA_WIDTH = 8
);

   logic                  spi_sclk;
   logic                  spi_ss_n;
   logic                  spi_mosi;
   logic                  spi_miso;
   logic                  spi_miso_oe;

   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_load;
   logic                  tx_ready;
   logic                  tx_underrun;

   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  busy;

   modport slave (
      input  spi_sclk,
      input  spi_ss_n,
      input  spi_mosi,
      output spi_miso,
      output spi_miso_oe,
      input  tx_data,
      input  tx_load,
      output tx_ready,
      output tx_underrun,
      output rx_data,
      output rx_valid,
      output busy
   );

   modport master (
      output spi_sclk,
      output spi_ss_n,
      output spi_mosi,
      input  spi_miso,
      input  spi_miso_oe,
      output tx_data,
      output tx_load,
      input  tx_ready,
      input  tx_underrun,
      input  rx_data,
      input  rx_valid,
      input  busy
   );

endinterface : spi_slave_responder_if

// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
//
// SPI mode-0 slave used as an on-chip far end for the platform SPI master
// (ADC stand-in / loopback target). SCLK, SS_n and MOSI are oversampled in
// the CLOCK_50 domain; received words go to local logic, reply words come
// from a single-entry holding register, with DEFAULT_TX substituted when
// that register is empty at the start of a word.
//
// Parameters
//   DATA_WIDTH   bits per SPI word, MSB first (4..32)
//   DEFAULT_TX   reply shifted out when no word is held
//
// Ports
//   CLOCK_50     system clock, all flops on its rising edge
//   RESET_N      synchronous active-low reset
//   bus          spi_slave_responder_if.slave: SPI pins, tx holding-register
//                handshake, rx word/strobe and busy
//
// Timing from a pin edge (SS_n or SCLK, changing between clock edges):
//   edge 1  first synchronizer stage
//   edge 2  second stage; rise/fall strobe decoded against the third stage
//   edge 3  FSM / shift registers act on the strobe
//   edge 4  registered pin-side outputs (MISO, MISO_OE, rx_data/rx_valid)
// -----------------------------------------------------------------------------
module spi_slave_responder #(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = DATA_WIDTH'(8'hA5)
) (
   input logic                  CLOCK_50,
   input logic                  RESET_N,
   spi_slave_responder_if.slave bus
);

   localparam int                CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronizers
   // Bit 0 is the first stage, bit 1 the synchronized value, bit 2 (SCLK and
   // SS_n only) the previous synchronized value used for edge detection.
   // ---------------------------------------------------------------------------
   logic [2:0] sclk_sync;
   logic [2:0] ss_sync;
   logic [1:0] mosi_sync;

   // NOTE: reset here is synchronous -- it is just another input sampled on
   // the clock edge, so it lives inside the clocked block, not in its list.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         // Preload the idle pin levels so release of reset cannot fake an edge.
         sclk_sync <= 3'b000;
         ss_sync   <= 3'b111;
         mosi_sync <= 2'b00;
      end else begin
         sclk_sync <= {sclk_sync[1:0], bus.spi_sclk};
         ss_sync   <= {ss_sync[1:0],   bus.spi_ss_n};
         mosi_sync <= {mosi_sync[0],   bus.spi_mosi};
      end
   end

   logic sclk_rise;
   logic sclk_fall;
   logic ss_n_s;
   logic ss_rise;
   logic mosi_s;

   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
   assign ss_n_s    = ss_sync[1];
   assign ss_rise   = ss_sync[1] & ~ss_sync[2];
   assign mosi_s    = mosi_sync[1];

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                 state;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   word_done;   // a full word was received; next SCLK fall starts a new one
   logic [DATA_WIDTH-1:0]  tx_shift;
   logic [DATA_WIDTH-1:0]  rx_shift;
   logic                   rx_done;     // internal: word completed this strobe, publish next cycle

   logic                   hold_full;
   logic [DATA_WIDTH-1:0]  hold_data;

   logic                   spi_miso_q;
   logic                   spi_miso_oe_q;
   logic                   tx_underrun_q;
   logic [DATA_WIDTH-1:0]  rx_data_q;
   logic                   rx_valid_q;

   // A new reply word is fetched on frame entry, and on the SCLK fall that
   // follows a completed word while SS_n stays low (back-to-back words).
   // SS_n rising wins over a fall in the same cycle: the frame is over.
   logic                   load_word;
   logic [DATA_WIDTH-1:0]  next_word;

   assign load_word = ((state == IDLE)   && !ss_n_s) ||
                      ((state == ACTIVE) && !ss_rise && sclk_fall && word_done);
   assign next_word = hold_full ? hold_data : DEFAULT_TX;

   // ---------------------------------------------------------------------------
   // FSM, shift registers, holding register and registered outputs
   // ---------------------------------------------------------------------------
   // NOTE: every register here uses non-blocking assignment, so each right-hand
   // side sees the value from before this edge regardless of statement order;
   // a later assignment to the same register in one pass overrides an earlier one.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         word_done     <= 1'b0;
         tx_shift      <= '0;
         rx_shift      <= '0;
         rx_done       <= 1'b0;
         // NOTE: the data registers are reset too; with a synchronous reset,
         // leaving them out would turn RESET_N into an enable term on their D input.
         hold_full     <= 1'b0;
         hold_data     <= '0;
         spi_miso_q    <= 1'b0;
         spi_miso_oe_q <= 1'b0;
         tx_underrun_q <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
      end else begin
         // Single-cycle pulses default low and are raised below when needed.
         tx_underrun_q <= 1'b0;
         rx_done       <= 1'b0;

         // Holding register. A transfer out only happens when it is full, and a
         // load is only accepted when it is empty, so a load coinciding with a
         // transfer is refused and the transferred word is the old one.
         if (load_word && hold_full) begin
            hold_full <= 1'b0;
         end else if (bus.tx_load && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= bus.tx_data;
         end

         case (state)
            IDLE: begin
               // SCLK edges seen here are ignored.
               if (load_word) begin
                  state         <= ACTIVE;
                  tx_shift      <= next_word;
                  tx_underrun_q <= !hold_full;
                  bit_cnt       <= '0;
                  word_done     <= 1'b0;
               end
            end

            ACTIVE: begin
               if (sclk_rise) begin
                  rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt   <= '0;
                     word_done <= 1'b1;
                     rx_done   <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end

               if (ss_rise) begin
                  // A word completing on this same strobe is still published via
                  // rx_done; any partial word is simply dropped.
                  state     <= IDLE;
                  bit_cnt   <= '0;
                  word_done <= 1'b0;
               end else if (sclk_fall) begin
                  if (word_done) begin
                     tx_shift      <= next_word;
                     tx_underrun_q <= !hold_full;
                     word_done     <= 1'b0;
                  end else begin
                     tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                  end
               end
            end

            default: state <= IDLE;
         endcase

         // Pin-side outputs follow the state one cycle later, so MISO and its
         // enable drop together in the cycle after IDLE is entered.
         spi_miso_q    <= (state == ACTIVE) ? tx_shift[DATA_WIDTH-1] : 1'b0;
         spi_miso_oe_q <= (state == ACTIVE);

         if (rx_done) begin
            rx_data_q <= rx_shift;
         end
         rx_valid_q <= rx_done;
      end
   end

   assign bus.spi_miso    = spi_miso_q;
   assign bus.spi_miso_oe = spi_miso_oe_q;
   assign bus.tx_ready    = ~hold_full;
   assign bus.tx_underrun = tx_underrun_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.busy        = (state == ACTIVE);

endmodule : spi_slave_responder

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_responder
//
// Directed bench for spi_slave_responder (8-bit words, DEFAULT_TX = 8'hA5).
// The bench plays the SPI master with 8-cycle SCLK periods (6.25 MHz) and keeps
// a transaction-level model of the responder:
//   - pin histories of SS_n and RESET_N give MISO_OE (4-cycle delay) and busy
//     (3-cycle delay);
//   - each completed word schedules an rx_valid pulse 4 cycles after the SCLK
//     rise that carried its last bit;
//   - each word start (frame entry, or the SCLK fall after a completed word)
//     takes the held reply word or, if none, DEFAULT_TX plus an underrun pulse
//     3 cycles after the pin edge.
// A per-cycle compare process checks the DUT against that model; the master
// checks every MISO bit it samples; literal checks pin the scenarios.
// Inputs change 5 ns after a rising clock edge; outputs are compared on the
// falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_responder;

   localparam int         W       = 8;
   localparam logic [7:0] DEF_TX  = 8'hA5;
   localparam int         HIST    = 20000;

   logic clk = 1'b0;
   logic rst_n;

   always #10 clk = ~clk;

   spi_slave_responder_if #(.DATA_WIDTH(W)) bus ();

   spi_slave_responder #(
      .DATA_WIDTH (W),
      .DEFAULT_TX (DEF_TX)
   ) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (bus)
   );

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #5;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Model state
   // ---------------------------------------------------------------------------
   typedef struct {
      int         cyc;
      logic [7:0] data;
   } rx_ev_t;

   rx_ev_t     rxq[$];          // expected rx_valid pulses
   int         uq[$];           // expected tx_underrun pulse cycles
   logic [7:0] miso_words[$];   // words the master has shifted in

   bit         hold_full_m = 1'b0;
   logic [7:0] hold_m      = '0;
   logic [7:0] cur_word    = '0;
   logic [7:0] rx_acc      = '0;
   logic [7:0] mword       = '0;
   int         bits_in     = 0;

   bit         rst_hist [0:HIST-1];
   bit         ss_hist  [0:HIST-1];
   logic [7:0] model_rx    = '0;
   int         rx_pulses   = 0;
   int         un_pulses   = 0;

   function automatic bit rst_at(input int c);
      return (c >= 0 && c < HIST) ? rst_hist[c] : 1'b0;
   endfunction

   function automatic bit ss_at(input int c);
      return (c >= 0 && c < HIST) ? ss_hist[c] : 1'b1;
   endfunction

   // A new word starts at the current pin cycle.
   task automatic word_start();
      if (hold_full_m) begin
         cur_word    = hold_m;
         hold_full_m = 1'b0;
      end else begin
         cur_word = DEF_TX;
         uq.push_back(cyc + 3);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Per-cycle compare
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      int  c;
      bit  exp_oe, exp_busy, exp_v, exp_u;
      c = cyc;
      if (c < HIST) begin
         rst_hist[c] = rst_n;
         ss_hist[c]  = bus.spi_ss_n;
      end

      exp_oe   = rst_at(c-4) && rst_at(c-3) && rst_at(c-2) && rst_at(c-1) && !ss_at(c-4);
      exp_busy = rst_at(c-3) && rst_at(c-2) && rst_at(c-1) && !ss_at(c-3);

      while (rxq.size() > 0 && rxq[0].cyc < c) void'(rxq.pop_front());
      exp_v = 1'b0;
      if (rxq.size() > 0 && rxq[0].cyc == c) begin
         exp_v    = 1'b1;
         model_rx = rxq[0].data;
         void'(rxq.pop_front());
      end

      while (uq.size() > 0 && uq[0] < c) void'(uq.pop_front());
      exp_u = 1'b0;
      if (uq.size() > 0 && uq[0] == c) begin
         exp_u = 1'b1;
         void'(uq.pop_front());
      end

      if (!rst_at(c-1)) begin
         exp_v    = 1'b0;
         exp_u    = 1'b0;
         model_rx = '0;
      end

      check("cyc_miso_oe",     bus.spi_miso_oe, exp_oe);
      check("cyc_busy",        bus.busy,        exp_busy);
      check("cyc_rx_valid",    bus.rx_valid,    exp_v);
      check("cyc_rx_data",     bus.rx_data,     model_rx);
      check("cyc_tx_underrun", bus.tx_underrun, exp_u);
      if (!exp_oe) check("cyc_miso_idle", bus.spi_miso, 1'b0);

      if (bus.rx_valid === 1'b1)    rx_pulses++;
      if (bus.tx_underrun === 1'b1) un_pulses++;
   end

   // ---------------------------------------------------------------------------
   // Master-side tasks
   // ---------------------------------------------------------------------------
   task automatic load(input logic [7:0] w);
      bus.tx_data = w;
      bus.tx_load = 1'b1;
      if (!hold_full_m) begin
         hold_m      = w;
         hold_full_m = 1'b1;
      end
      tick();
      bus.tx_load = 1'b0;
   endtask

   task automatic select();
      bus.spi_ss_n = 1'b0;
      bits_in      = 0;
      word_start();
   endtask

   task automatic deselect();
      tick(4);
      bus.spi_ss_n = 1'b1;
      tick(6);
   endtask

   // Clock n bits out of 'bits', MSB first; MOSI changes with each SCLK fall.
   task automatic clock_bits(input int n, input logic [31:0] bits);
      for (int i = 0; i < n; i++) begin
         logic b;
         int   j;
         b            = bits[n-1-i];
         bus.spi_mosi = b;
         tick(4);
         j = bits_in % 8;
         check("miso_bit", bus.spi_miso, cur_word[7-j]);
         mword        = {mword[6:0], bus.spi_miso};
         bus.spi_sclk = 1'b1;
         rx_acc       = {rx_acc[6:0], b};
         bits_in++;
         if (bits_in % 8 == 0) begin
            rx_ev_t ev;
            ev.cyc  = cyc + 4;
            ev.data = rx_acc;
            rxq.push_back(ev);
            miso_words.push_back(mword);
         end
         tick(4);
         bus.spi_sclk = 1'b0;
         if (bits_in % 8 == 0) word_start();
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   initial begin
      int p0, u0;
      rst_n        = 1'b0;
      bus.spi_ss_n = 1'b1;
      bus.spi_sclk = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.tx_data  = '0;
      bus.tx_load  = 1'b0;

      // Reset then idle
      tick(3);
      check("reset_miso",        bus.spi_miso,    1'b0);
      check("reset_miso_oe",     bus.spi_miso_oe, 1'b0);
      check("reset_tx_ready",    bus.tx_ready,    1'b1);
      check("reset_tx_underrun", bus.tx_underrun, 1'b0);
      check("reset_rx_data",     bus.rx_data,     8'h00);
      check("reset_rx_valid",    bus.rx_valid,    1'b0);
      check("reset_busy",        bus.busy,        1'b0);
      rst_n = 1'b1;
      tick(4);

      // Single word: reply 3C, master sends C5
      load(8'h3C);
      check("load_tx_ready", bus.tx_ready, 1'b0);
      p0 = rx_pulses;
      select();
      tick(4);
      check("start_tx_ready", bus.tx_ready, 1'b1);
      clock_bits(8, 32'h0000_00C5);
      deselect();
      check("single_rx_data",   bus.rx_data,           8'hC5);
      check("single_miso_word", miso_words[$],         8'h3C);
      check("single_rx_pulses", rx_pulses - p0,        1);

      // Underrun, back-to-back 01 then 02. The SCLK fall after each completed
      // word starts a new one, so there are three word starts, all underruns.
      p0 = rx_pulses;
      u0 = un_pulses;
      select();
      clock_bits(16, 32'h0000_0102);
      deselect();
      check("b2b_rx_data",     bus.rx_data,               8'h02);
      check("b2b_rx_pulses",   rx_pulses - p0,            2);
      check("b2b_underruns",   un_pulses - u0,            3);
      check("b2b_miso_word0",  miso_words[$-1],           8'hA5);
      check("b2b_miso_word1",  miso_words[$],             8'hA5);

      // Abort after 5 bits, then a full frame
      p0 = rx_pulses;
      select();
      clock_bits(5, 32'h0000_001F);
      deselect();
      check("abort_rx_data",   bus.rx_data,     8'h02);
      check("abort_rx_pulses", rx_pulses - p0,  0);
      check("abort_miso_oe",   bus.spi_miso_oe, 1'b0);
      check("abort_busy",      bus.busy,        1'b0);
      select();
      clock_bits(8, 32'h0000_005A);
      deselect();
      check("after_abort_rx_data", bus.rx_data, 8'h5A);

      // Load while full: 11 kept, 22 dropped
      load(8'h11);
      load(8'h22);
      check("full_tx_ready", bus.tx_ready, 1'b0);
      select();
      clock_bits(8, 32'h0000_0096);
      deselect();
      check("full_miso_word", miso_words[$], 8'h11);
      check("full_rx_data",   bus.rx_data,   8'h96);
      check("full_tx_ready_after", bus.tx_ready, 1'b1);

      // Reset mid-frame after 3 bits, released with SS_n still low
      select();
      clock_bits(3, 32'h0000_0005);
      rst_n = 1'b0;
      for (int i = rxq.size() - 1; i >= 0; i--) if (rxq[i].cyc > cyc) rxq.delete(i);
      for (int i = uq.size() - 1; i >= 0; i--)  if (uq[i] > cyc)      uq.delete(i);
      hold_full_m = 1'b0;
      tick(3);
      check("midrst_rx_data",  bus.rx_data,     8'h00);
      check("midrst_miso_oe",  bus.spi_miso_oe, 1'b0);
      check("midrst_busy",     bus.busy,        1'b0);
      check("midrst_tx_ready", bus.tx_ready,    1'b1);
      rst_n   = 1'b1;
      bits_in = 0;
      word_start();
      tick(6);
      check("midrst_reentry_busy", bus.busy, 1'b1);
      clock_bits(8, 32'h0000_007E);
      deselect();
      check("midrst_rx_data_after", bus.rx_data,   8'h7E);
      check("midrst_miso_word",     miso_words[$], 8'hA5);

      tick(8);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_spi_slave_responder
